regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameters SHALL be, one per line (name, default, meaning):
  DW  32  data width
  AW  5  address width; depth = 2**AW
  NRD  2  read ports
  NWR  2  write ports
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  in  1  clock
  rst  in  1  asynchronous active-low reset
  we  in  NWR  write enable per port
  waddr  in  NWR*AW  write addresses, port k at bits [k*AW +: AW]
  wdata  in  NWR*DW  write data, port k at bits [k*DW +: DW]
  re  in  NRD  read enable per port
  raddr  in  NRD*AW  read addresses, packed as waddr
  rdata  out  NRD*DW  read data, packed as wdata
  sb_set  in  1  mark register sb_addr pending (load issued)
  sb_addr  in  AW  scoreboard target
  flush  in  1  clear all pending marks
  busy  out  NRD  read port i source pending, not yet forwardable
  sb_cnt  out  AW+1  number of pending registers
  wr_conflict  out  1  registered same-address dual-write flag

Function
REQ-004 Register 0 SHALL read as zero, ignore writes and never be marked pending.
REQ-005 Writes SHALL occur at posedge clk for each port with we[k]=1 and waddr!=0.
REQ-006 Two or more ports writing the same nonzero address in one cycle SHALL store the data of the highest-index port.
REQ-007 wr_conflict SHALL be 1 in the cycle after any same-address nonzero multi-write, else 0.
REQ-008 rdata[i] SHALL be combinational, with priority: address 0 -> 0; re[i]=0 -> 0; address matches an active write port -> wdata of the highest-index matching port (bypass); else stored value.
REQ-009 Pending bit p[r] SHALL set at posedge when sb_set=1 and sb_addr=r!=0.
REQ-010 p[r] SHALL clear at posedge when any write port writes r.
REQ-011 If set and clear hit the same register in one cycle, set SHALL win.
REQ-012 flush=1 SHALL clear all pending bits and SHALL override sb_set in the same cycle.
REQ-013 busy[i] SHALL equal re[i] & p[raddr_i] & (raddr_i!=0) & no active write to raddr_i this cycle.
REQ-014 sb_cnt SHALL be a registered count equal to the population of p after each edge, range 0..2**AW-1.
REQ-015 Setting an already-pending register SHALL leave p and sb_cnt unchanged.
REQ-016 Read-only activity SHALL never change state.

Reset
REQ-017 While rst=0, all registers, p, sb_cnt and wr_conflict SHALL be 0 immediately, independent of clk.
REQ-018 While rst=0, rdata SHALL be 0 and busy SHALL be 0.
REQ-019 A reset assertion mid-operation SHALL discard in-flight writes and marks; the first edge after release SHALL behave as from cold.

Verification
REQ-020 The bench SHALL cover: write r5=0xDEADBEEF on port 0, then read r5 on both ports next cycle -> both rdata=0xDEADBEEF.
REQ-021 The bench SHALL cover: same cycle port0 writes r7=0x1, port1 writes r7=0x2, read r7 -> bypass 0x2; next cycle stored r7=0x2 and wr_conflict=1; one cycle later wr_conflict=0.
REQ-022 The bench SHALL cover: sb_set r9, then read r9 -> busy=1 and sb_cnt=1; write r9=0x55 with read r9 in that cycle -> busy=0 and rdata=0x55; next cycle sb_cnt=0.
REQ-023 The bench SHALL cover: sb_set r3 in the same cycle as a write to r3 -> p[3]=1 and sb_cnt=1; flush plus sb_set r4 in one cycle -> sb_cnt=0.
REQ-024 The bench SHALL cover: write r0=0xFFFF and sb_set r0 -> rdata(r0)=0, busy=0 and sb_cnt=0.
REQ-025 The bench SHALL cover: fill r1..r3 and mark r1 pending, assert rst=0 between edges -> all reads 0 and sb_cnt=0 immediately; after release, r1 reads 0.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file with a per-register pending scoreboard for in-flight loads.
// Latency: writes and scoreboard updates land at posedge; reads, write bypass and busy are combinational.
// Backpressure: none; busy tells a consumer its source is pending and not forwardable this cycle.
module regfile_mp #(
    parameter int DW  = 32,
    parameter int AW  = 5,
    parameter int NRD = 2,
    parameter int NWR = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*DW-1:0]   wdata,
    input  logic [NRD-1:0]      re,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*DW-1:0]   rdata,
    input  logic                sb_set,
    input  logic [AW-1:0]       sb_addr,
    input  logic                flush,
    output logic [NRD-1:0]      busy,
    output logic [AW:0]         sb_cnt,
    output logic                wr_conflict
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] pend;
    logic [DEPTH-1:0] pend_nxt;
    logic [DEPTH-1:0] wr_hit;
    logic             conflict;
    logic [AW:0]      cnt_nxt;
    logic [AW-1:0]    ra;
    logic [DW-1:0]    rv;

    // Which registers get written this cycle (register 0 is never a real target)
    always_comb begin
        wr_hit = '0;
        for (int k = 0; k < NWR; k++) begin
            if (we[k] && waddr[k*AW +: AW] != '0) begin
                wr_hit[waddr[k*AW +: AW]] = 1'b1;
            end
        end
    end

    // Any two active ports hitting the same nonzero register
    always_comb begin
        conflict = 1'b0;
        for (int a = 0; a < NWR; a++) begin
            for (int b = a + 1; b < NWR; b++) begin
                if (we[a] && we[b] && waddr[a*AW +: AW] == waddr[b*AW +: AW] &&
                    waddr[a*AW +: AW] != '0) begin
                    conflict = 1'b1;
                end
            end
        end
    end

    // Next pending set: flush beats everything, a new mark beats a same-cycle writeback clear
    always_comb begin
        pend_nxt = flush ? '0 : (pend & ~wr_hit);
        if (!flush && sb_set && sb_addr != '0) begin
            pend_nxt[sb_addr] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
        cnt_nxt = '0;
        for (int r = 0; r < DEPTH; r++) begin
            cnt_nxt = cnt_nxt + {{AW{1'b0}}, pend_nxt[r]};
        end
    end

    // Storage array; ascending port order makes the highest-index port win a same-address write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem[r] <= '0;
            end
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (we[k] && waddr[k*AW +: AW] != '0) begin
                    mem[waddr[k*AW +: AW]] <= wdata[k*DW +: DW];
                end
            end
        end
    end

    // Scoreboard, its population count and the registered conflict flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend        <= '0;
            sb_cnt      <= '0;
            wr_conflict <= 1'b0;
        end else begin
            pend        <= pend_nxt;
            sb_cnt      <= cnt_nxt;
            wr_conflict <= conflict;
        end
    end

    // Read ports with write bypass; outputs held at zero while in reset
    always_comb begin
        rdata = '0;
        busy  = '0;
        ra    = '0;
        rv    = '0;
        for (int i = 0; i < NRD; i++) begin
            ra = raddr[i*AW +: AW];
            rv = mem[ra];
            for (int k = 0; k < NWR; k++) begin
                if (we[k] && waddr[k*AW +: AW] == ra) begin
                    rv = wdata[k*DW +: DW];
                end
            end
            if (!rst || !re[i] || ra == '0) begin
                rv = '0;
            end
            rdata[i*DW +: DW] = rv;
            busy[i] = rst & re[i] & (ra != '0) & pend[ra] & ~wr_hit[ra];
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized and directed bench for regfile_mp against an array-based reference model.
// Latency: combinational outputs checked at negedge, registered outputs 1 time unit after posedge.
// Backpressure: not applicable; every cycle is driven and checked.
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NRD = 2;
    localparam int NWR = 2;
    localparam int DEPTH = 1 << AW;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NWR-1:0]    we = '0;
    logic [NWR*AW-1:0] waddr = '0;
    logic [NWR*DW-1:0] wdata = '0;
    logic [NRD-1:0]    re = '0;
    logic [NRD*AW-1:0] raddr = '0;
    logic [NRD*DW-1:0] rdata;
    logic              sb_set = 1'b0;
    logic [AW-1:0]     sb_addr = '0;
    logic              flush = 1'b0;
    logic [NRD-1:0]    busy;
    logic [AW:0]       sb_cnt;
    logic              wr_conflict;

    int n_tests = 0;
    int n_fail  = 0;

    // reference state
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_pend [DEPTH];
    int            m_cnt;
    bit            m_conf;

    regfile_mp #(.DW(DW), .AW(AW), .NRD(NRD), .NWR(NWR)) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rdata), .sb_set(sb_set), .sb_addr(sb_addr),
        .flush(flush), .busy(busy), .sb_cnt(sb_cnt), .wr_conflict(wr_conflict)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] wa(input int k);
        return waddr[k*AW +: AW];
    endfunction

    function automatic logic [AW-1:0] rda(input int i);
        return raddr[i*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] rdp(input int i);
        return rdata[i*DW +: DW];
    endfunction

    function automatic logic [DW-1:0] exp_read(input int i);
        logic [DW-1:0] v;
        int a;
        a = rda(i);
        if (a == 0 || !re[i]) return '0;
        v = m_mem[a];
        for (int k = 0; k < NWR; k++)
            if (we[k] && wa(k) == a) v = wdata[k*DW +: DW];
        return v;
    endfunction

    function automatic bit written_now(input int a);
        for (int k = 0; k < NWR; k++)
            if (we[k] && wa(k) == a && a != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit exp_busy(input int i);
        int a;
        a = rda(i);
        return re[i] && a != 0 && m_pend[a] && !written_now(a);
    endfunction

    task automatic model_reset();
        for (int r = 0; r < DEPTH; r++) begin
            m_mem[r] = '0;
            m_pend[r] = 1'b0;
        end
        m_cnt = 0;
        m_conf = 1'b0;
    endtask

    task automatic model_edge();
        bit wr [DEPTH];
        m_conf = 1'b0;
        for (int r = 0; r < DEPTH; r++) wr[r] = 1'b0;
        for (int k = 0; k < NWR; k++) begin
            if (we[k] && wa(k) != 0) begin
                if (wr[wa(k)]) m_conf = 1'b1;
                wr[wa(k)] = 1'b1;
                m_mem[wa(k)] = wdata[k*DW +: DW];
            end
        end
        for (int r = 1; r < DEPTH; r++) begin
            if (flush) m_pend[r] = 1'b0;
            else if (sb_set && sb_addr == r) m_pend[r] = 1'b1;
            else if (wr[r]) m_pend[r] = 1'b0;
        end
        m_cnt = 0;
        for (int r = 1; r < DEPTH; r++) m_cnt += int'(m_pend[r]);
    endtask

    task automatic idle();
        we = '0; waddr = '0; wdata = '0; re = '0; raddr = '0;
        sb_set = 1'b0; sb_addr = '0; flush = 1'b0;
    endtask

    task automatic set_wr(input int k, input int a, input logic [DW-1:0] d);
        we[k] = 1'b1;
        waddr[k*AW +: AW] = AW'(a);
        wdata[k*DW +: DW] = d;
    endtask

    task automatic set_rd(input int i, input int a);
        re[i] = 1'b1;
        raddr[i*AW +: AW] = AW'(a);
    endtask

    // one clock: compare combinational outputs, take the edge, compare registered outputs
    task automatic cycle();
        @(negedge clk);
        for (int i = 0; i < NRD; i++) begin
            check($sformatf("rdata%0d", i), 64'(rdp(i)), 64'(exp_read(i)));
            check($sformatf("busy%0d", i), 64'(busy[i]), 64'(exp_busy(i)));
        end
        @(posedge clk);
        model_edge();
        #1;
        check("sb_cnt", 64'(sb_cnt), 64'(m_cnt));
        check("wr_conflict", 64'(wr_conflict), 64'(m_conf));
    endtask

    initial begin
        model_reset();
        idle();
        #12;
        set_rd(0, 1); set_rd(1, 2);
        #1;
        check("rst_rdata0", 64'(rdp(0)), 64'h0);
        check("rst_sb_cnt", 64'(sb_cnt), 64'h0);
        check("rst_conflict", 64'(wr_conflict), 64'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        idle();

        // write r5 then read it on both ports
        set_wr(0, 5, 32'hDEADBEEF);
        cycle(); idle();
        set_rd(0, 5); set_rd(1, 5);
        #1;
        check("r5_p0", 64'(rdp(0)), 64'hDEADBEEF);
        check("r5_p1", 64'(rdp(1)), 64'hDEADBEEF);
        cycle(); idle();

        // dual write to r7: bypass, store and conflict flag
        set_wr(0, 7, 32'h1); set_wr(1, 7, 32'h2); set_rd(0, 7);
        #1;
        check("r7_bypass", 64'(rdp(0)), 64'h2);
        cycle(); idle();
        check("r7_conflict", 64'(wr_conflict), 64'h1);
        set_rd(1, 7);
        #1;
        check("r7_stored", 64'(rdp(1)), 64'h2);
        cycle(); idle();
        check("r7_conflict_clr", 64'(wr_conflict), 64'h0);

        // mark r9, see busy, resolve with a write
        sb_set = 1'b1; sb_addr = 5'd9;
        cycle(); idle();
        check("r9_cnt1", 64'(sb_cnt), 64'h1);
        set_rd(0, 9);
        #1;
        check("r9_busy", 64'(busy[0]), 64'h1);
        cycle(); idle();
        set_rd(0, 9); set_wr(1, 9, 32'h55);
        #1;
        check("r9_busy_wr", 64'(busy[0]), 64'h0);
        check("r9_bypass", 64'(rdp(0)), 64'h55);
        cycle(); idle();
        check("r9_cnt0", 64'(sb_cnt), 64'h0);

        // set beats clear; flush beats set
        sb_set = 1'b1; sb_addr = 5'd3; set_wr(0, 3, 32'h33);
        cycle(); idle();
        check("r3_setwin", 64'(sb_cnt), 64'h1);
        set_rd(0, 3);
        #1;
        check("r3_busy", 64'(busy[0]), 64'h1);
        cycle(); idle();
        flush = 1'b1; sb_set = 1'b1; sb_addr = 5'd4;
        cycle(); idle();
        check("flush_cnt", 64'(sb_cnt), 64'h0);

        // register 0 is inert
        set_wr(0, 0, 32'hFFFF); sb_set = 1'b1; sb_addr = 5'd0;
        cycle(); idle();
        set_rd(0, 0); set_rd(1, 0);
        #1;
        check("r0_rdata", 64'(rdp(0)), 64'h0);
        check("r0_busy", 64'(busy[0]), 64'h0);
        check("r0_cnt", 64'(sb_cnt), 64'h0);
        cycle(); idle();

        // randomized traffic, concentrated on low registers to provoke collisions
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < NWR; k++)
                if ($urandom_range(0, 2) != 0)
                    set_wr(k, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 6)), $urandom);
            for (int i = 0; i < NRD; i++)
                if ($urandom_range(0, 3) != 0)
                    set_rd(i, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 6)));
            sb_set  = ($urandom_range(0, 1) == 1);
            sb_addr = AW'($urandom_range(0, 10));
            flush   = ($urandom_range(0, 31) == 0);
            cycle(); idle();
        end

        // mid-operation reset
        flush = 1'b1;
        cycle(); idle();
        set_wr(0, 1, 32'h11); set_wr(1, 2, 32'h22);
        cycle(); idle();
        set_wr(0, 3, 32'h33); sb_set = 1'b1; sb_addr = 5'd1;
        cycle(); idle();
        set_rd(0, 1); set_rd(1, 3); set_wr(0, 1, 32'hAA);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("arst_rd0", 64'(rdp(0)), 64'h0);
        check("arst_rd1", 64'(rdp(1)), 64'h0);
        check("arst_busy", 64'(busy), 64'h0);
        check("arst_cnt", 64'(sb_cnt), 64'h0);
        @(negedge clk);
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        set_rd(0, 1); set_rd(1, 3);
        #1;
        check("post_rst_r1", 64'(rdp(0)), 64'h0);
        check("post_rst_r3", 64'(rdp(1)), 64'h0);
        cycle(); idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // hard time limit so the run can never hang
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
